// File: rtl/lsu_unit.sv
// RV32I load/store unit: drives a req/gnt/rvalid data bus from the latched ALU address and returns extended load data.
// Latency: store 2 cycles, load 3 cycles, error 1 cycle; o_stall holds the core until the single-cycle o_done pulse.
module lsu_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_lsu_valid,
  input  logic        i_lsu_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_st_data,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_ld_data,
  output logic        o_err,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_bmask,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] st_data;
  } lsu_req_t;

  // DONE is the last budgeted cycle, so the REQ/WAIT phase gives up two counts early.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 2);

  state_t      state_q, state_d;
  lsu_req_t    req_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic        capture;
  logic        acc_legal, acc_misal, timeout_hit;
  logic [1:0]  off;
  logic [31:0] rdata_sh;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Acceptance-time decode of the incoming instruction.
  always_comb begin
    acc_legal = 1'b0;
    case (i_funct3)
      3'b000, 3'b001, 3'b010: acc_legal = 1'b1;
      3'b100, 3'b101:         acc_legal = ~i_lsu_we;
      default:                acc_legal = 1'b0;
    endcase
    acc_misal = ((i_funct3[1:0] == 2'b01) & i_addr[0]) |
                ((i_funct3[1:0] == 2'b10) & (|i_addr[1:0]));
  end

  assign off      = req_q.addr[1:0];
  assign rdata_sh = i_mem_rdata >> {off, 3'b000};
  assign ld_byte  = rdata_sh[7:0];
  assign ld_half  = off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

  always_comb begin
    ld_ext = i_mem_rdata;
    case (req_q.funct3)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = i_mem_rdata;
    endcase
  end

  assign timeout_hit = (cnt_q >= TO_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    ld_data_d = ld_data_q;
    capture   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_lsu_valid) begin
          capture = 1'b1;
          cnt_d   = 8'd0;
          if (!acc_legal || acc_misal) begin
            state_d   = S_DONE;
            err_d     = 1'b1;
            ld_data_d = 32'h0;
          end else begin
            state_d = S_REQ;
            err_d   = 1'b0;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 8'd1;
        // A grant on the expiry cycle still wins over the timeout.
        if (i_mem_gnt) begin
          state_d = req_q.we ? S_DONE : S_WAIT;
        end else if (timeout_hit) begin
          state_d   = S_DONE;
          err_d     = 1'b1;
          ld_data_d = 32'h0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (i_mem_rvalid) begin
          state_d   = S_DONE;
          ld_data_d = ld_ext;
        end else if (timeout_hit) begin
          state_d   = S_DONE;
          err_d     = 1'b1;
          ld_data_d = 32'h0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      req_q     <= '0;
      cnt_q     <= 8'd0;
      err_q     <= 1'b0;
      ld_data_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      ld_data_q <= ld_data_d;
      if (capture) begin
        req_q <= '{we: i_lsu_we, funct3: i_funct3, addr: i_addr, st_data: i_st_data};
      end
    end
  end

  // Stall is gated by reset so every output reads 0 while reset is held.
  assign o_stall    = i_rst_n & i_lsu_valid & (state_q != S_DONE);
  assign o_done     = (state_q == S_DONE);
  assign o_err      = o_done & err_q;
  assign o_ld_data  = ld_data_q;
  assign o_mem_req  = (state_q == S_REQ);
  assign o_mem_we   = req_q.we;
  assign o_mem_addr = {req_q.addr[31:2], 2'b00};

  always_comb begin
    o_mem_wdata = req_q.st_data;
    o_mem_bmask = 4'b0000;
    case (req_q.funct3[1:0])
      2'b00:   o_mem_wdata = {4{req_q.st_data[7:0]}};
      2'b01:   o_mem_wdata = {2{req_q.st_data[15:0]}};
      default: o_mem_wdata = req_q.st_data;
    endcase
    if (req_q.we) begin
      case (req_q.funct3[1:0])
        2'b00:   o_mem_bmask = 4'b0001 << off;
        2'b01:   o_mem_bmask = 4'b0011 << off;
        default: o_mem_bmask = 4'b1111;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_unit.sv
// Self-checking bench for lsu_unit: directed scenarios plus randomized accesses against an arithmetic reference model.
module tb_lsu_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_valid, lsu_we;
  logic [2:0]  funct3;
  logic [31:0] addr, st_data;
  logic        stall, done, err;
  logic [31:0] ld_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_bmask;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  int          ob_req_cyc, ob_done_cyc;
  logic [31:0] ob_addr, ob_wdata, ob_ld;
  logic [3:0]  ob_bmask;
  logic        ob_we, ob_err, ob_stable, ob_stall_ok;

  lsu_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_lsu_valid(lsu_valid), .i_lsu_we(lsu_we),
    .i_funct3(funct3), .i_addr(addr), .i_st_data(st_data),
    .o_stall(stall), .o_done(done), .o_ld_data(ld_data), .o_err(err),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .o_mem_bmask(mem_bmask),
    .i_mem_gnt(mem_gnt), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Reference model: access size, lane mask and extension from plain arithmetic.
  function automatic void ref_model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                    input logic [31:0] d, input logic [31:0] rd,
                                    output logic e, output logic [3:0] bm,
                                    output logic [31:0] wd, output logic [31:0] ld);
    int size, o;
    logic legal;
    logic [31:0] mask, v;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    o     = int'(a[1:0]);
    e     = !legal || (o % size != 0);
    bm    = we ? 4'(((1 << size) - 1) << o) : 4'b0000;
    wd    = (size == 1) ? {24'h0, d[7:0]} * 32'h01010101 :
            (size == 2) ? {16'h0, d[15:0]} * 32'h00010001 : d;
    mask  = (size == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * size)) - 32'h1;
    v     = (rd >> (8 * o)) & mask;
    if (!f3[2] && size < 4 && (v & ((mask >> 1) + 32'h1)) != 32'h0) v = v | ~mask;
    ld    = e ? 32'h0 : v;
  endfunction

  // Bus responder: presents one access, grants after gnt_dly REQ cycles, returns data rv_dly cycles into WAIT.
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] rd,
                            input int gnt_dly, input int rv_dly, input logic noise);
    int cyc, rq, wt;
    logic gnt_given, fin;
    @(negedge clk);
    lsu_valid = 1'b1; lsu_we = we; funct3 = f3; addr = a; st_data = d;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
    cyc = 0; rq = 0; wt = 0; gnt_given = 1'b0; fin = 1'b0;
    ob_done_cyc = -1; ob_stable = 1'b1; ob_stall_ok = 1'b1; ob_err = 1'b0; ob_ld = 32'h0;
    ob_addr = 32'h0; ob_wdata = 32'h0; ob_bmask = 4'h0; ob_we = 1'b0;
    while (!fin && cyc < 60) begin
      @(negedge clk);
      cyc++;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (done) begin
        fin = 1'b1; ob_done_cyc = cyc; ob_err = err; ob_ld = ld_data;
        if (stall || mem_req) ob_stall_ok = 1'b0;
      end else begin
        if (!stall) ob_stall_ok = 1'b0;
        if (mem_req) begin
          rq++;
          if (rq == 1) begin
            ob_addr = mem_addr; ob_wdata = mem_wdata; ob_bmask = mem_bmask; ob_we = mem_we;
          end else if (mem_addr !== ob_addr || mem_wdata !== ob_wdata ||
                       mem_bmask !== ob_bmask || mem_we !== ob_we) begin
            ob_stable = 1'b0;
          end
          if (rq - 1 == gnt_dly) begin
            mem_gnt = 1'b1; gnt_given = 1'b1;
          end else if (noise) begin
            mem_rvalid = 1'b1;
          end
        end else if (gnt_given) begin
          wt++;
          if (wt - 1 == rv_dly) begin
            mem_rvalid = 1'b1; mem_rdata = rd;
          end
        end
      end
    end
    ob_req_cyc = rq;
  endtask

  task automatic test_reset();
    lsu_valid = 1'b1; lsu_we = 1'b1; funct3 = 3'b010; addr = 32'h100; st_data = 32'hFFFF_FFFF;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if ({mem_req, done, err} !== 3'b000) begin errors++; $display("FAIL reset_req_done_err got=%b exp=000", {mem_req, done, err}); end
    checks++; if (ld_data !== 32'h0) begin errors++; $display("FAIL reset_ld_data got=%h exp=0", ld_data); end
    checks++; if ({mem_we, mem_addr, mem_wdata, mem_bmask} !== 69'h0) begin errors++; $display("FAIL reset_bus got=%b/%h/%h/%h exp=0", mem_we, mem_addr, mem_wdata, mem_bmask); end
    lsu_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if ({mem_req, stall, done} !== 3'b000) begin errors++; $display("FAIL idle_after_reset got=%b exp=000", {mem_req, stall, done}); end
  endtask

  task automatic test_store();
    run_access(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 0, 0, 1'b0);
    lsu_valid = 1'b0;
    checks++; if (ob_req_cyc !== 1) begin errors++; $display("FAIL sw_req_cycles got=%0d exp=1", ob_req_cyc); end
    checks++; if ({ob_we, ob_addr, ob_bmask} !== {1'b1, 32'h100, 4'b1111}) begin errors++; $display("FAIL sw_bus got=%b/%h/%b exp=1/00000100/1111", ob_we, ob_addr, ob_bmask); end
    checks++; if (ob_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_wdata got=%h exp=deadbeef", ob_wdata); end
    checks++; if (ob_done_cyc !== 2 || ob_err !== 1'b0) begin errors++; $display("FAIL sw_done got=%0d/%b exp=2/0", ob_done_cyc, ob_err); end
    run_access(1'b1, 3'b000, 32'h103, 32'h0000_00A5, 32'h0, 0, 0, 1'b0);
    lsu_valid = 1'b0;
    checks++; if ({ob_addr, ob_bmask} !== {32'h100, 4'b1000}) begin errors++; $display("FAIL sb_lane got=%h/%b exp=00000100/1000", ob_addr, ob_bmask); end
    checks++; if (ob_wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_wdata got=%h exp=a5a5a5a5", ob_wdata); end
    checks++; if (ob_done_cyc !== 2 || ob_err !== 1'b0 || ob_stall_ok !== 1'b1) begin errors++; $display("FAIL sb_done got=%0d/%b/%b exp=2/0/1", ob_done_cyc, ob_err, ob_stall_ok); end
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3s [4];
    logic [31:0] as  [4];
    logic [31:0] exp [4];
    f3s = '{3'b001, 3'b101, 3'b000, 3'b100};
    as  = '{32'h202, 32'h202, 32'h203, 32'h203};
    exp = '{32'hFFFF_80FF, 32'h0000_80FF, 32'hFFFF_FF80, 32'h0000_0080};
    for (int i = 0; i < 4; i++) begin
      run_access(1'b0, f3s[i], as[i], 32'h0, 32'h80FF_1234, 0, 0, 1'b0);
      lsu_valid = 1'b0;
      checks++; if (ob_ld !== exp[i]) begin errors++; $display("FAIL load_ext[%0d] got=%h exp=%h", i, ob_ld, exp[i]); end
      checks++; if (ob_done_cyc !== 3 || ob_err !== 1'b0) begin errors++; $display("FAIL load_done[%0d] got=%0d/%b exp=3/0", i, ob_done_cyc, ob_err); end
      checks++; if ({ob_we, ob_bmask, ob_addr} !== {1'b0, 4'b0000, 32'h200}) begin errors++; $display("FAIL load_bus[%0d] got=%b/%b/%h exp=0/0000/00000200", i, ob_we, ob_bmask, ob_addr); end
    end
  endtask

  task automatic test_errors();
    logic        wes [4];
    logic [2:0]  f3s [4];
    logic [31:0] as  [4];
    wes = '{1'b0, 1'b0, 1'b1, 1'b1};
    f3s = '{3'b010, 3'b011, 3'b001, 3'b100};
    as  = '{32'h201, 32'h200, 32'h1, 32'h300};
    for (int i = 0; i < 4; i++) begin
      run_access(wes[i], f3s[i], as[i], 32'h1234_5678, 32'hFFFF_FFFF, 0, 0, 1'b0);
      lsu_valid = 1'b0;
      checks++; if (ob_req_cyc !== 0) begin errors++; $display("FAIL err_no_req[%0d] got=%0d exp=0", i, ob_req_cyc); end
      checks++; if (ob_done_cyc !== 1 || ob_err !== 1'b1 || ob_ld !== 32'h0) begin errors++; $display("FAIL err_done[%0d] got=%0d/%b/%h exp=1/1/0", i, ob_done_cyc, ob_err, ob_ld); end
    end
  endtask

  task automatic test_timeout();
    run_access(1'b1, 3'b010, 32'h440, 32'h5555_AAAA, 32'h0, 1000, 0, 1'b0);
    lsu_valid = 1'b0;
    checks++; if (ob_req_cyc !== TO - 1 || ob_stable !== 1'b1) begin errors++; $display("FAIL to_req_hold got=%0d/%b exp=%0d/1", ob_req_cyc, ob_stable, TO - 1); end
    checks++; if (ob_done_cyc !== TO || ob_err !== 1'b1) begin errors++; $display("FAIL to_store_done got=%0d/%b exp=%0d/1", ob_done_cyc, ob_err, TO); end
    run_access(1'b0, 3'b010, 32'h448, 32'h0, 32'h1111_2222, 0, 1000, 1'b0);
    lsu_valid = 1'b0;
    checks++; if (ob_done_cyc !== TO || ob_err !== 1'b1 || ob_ld !== 32'h0) begin errors++; $display("FAIL to_load_done got=%0d/%b/%h exp=%0d/1/0", ob_done_cyc, ob_err, ob_ld, TO); end
    run_access(1'b1, 3'b010, 32'h44C, 32'h0BAD_F00D, 32'h0, TO - 2, 0, 1'b0);
    lsu_valid = 1'b0;
    checks++; if (ob_done_cyc !== TO || ob_err !== 1'b0) begin errors++; $display("FAIL to_gnt_at_expiry got=%0d/%b exp=%0d/0", ob_done_cyc, ob_err, TO); end
    run_access(1'b1, 3'b010, 32'h450, 32'hCAFE_0001, 32'h0, 5, 0, 1'b0);
    lsu_valid = 1'b0;
    checks++; if (ob_done_cyc !== 7 || ob_err !== 1'b0 || ob_stable !== 1'b1) begin errors++; $display("FAIL gnt_delay5 got=%0d/%b/%b exp=7/0/1", ob_done_cyc, ob_err, ob_stable); end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    lsu_valid = 1'b1; lsu_we = 1'b0; funct3 = 3'b010; addr = 32'h300; st_data = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    checks++; if ({mem_req, stall} !== 2'b01) begin errors++; $display("FAIL wait_state got=%b exp=01", {mem_req, stall}); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({mem_req, stall, done} !== 3'b000) begin errors++; $display("FAIL async_reset got=%b exp=000", {mem_req, stall, done}); end
    @(negedge clk);
    rst_n = 1'b1; lsu_valid = 1'b0;
    @(negedge clk);
    mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'h7777_7777;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_rvalid = 1'b0; mem_gnt = 1'b0;
      checks++; if ({mem_req, done, err} !== 3'b000) begin errors++; $display("FAIL late_rvalid[%0d] got=%b exp=000", i, {mem_req, done, err}); end
    end
    run_access(1'b0, 3'b010, 32'h300, 32'h0, 32'h0123_4567, 0, 0, 1'b0);
    lsu_valid = 1'b0;
    checks++; if (ob_done_cyc !== 3 || ob_err !== 1'b0 || ob_ld !== 32'h0123_4567) begin errors++; $display("FAIL lw_after_reset got=%0d/%b/%h exp=3/0/01234567", ob_done_cyc, ob_err, ob_ld); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    rd = $urandom;
    // The store stays presented through its DONE cycle; it must not be accepted again.
    run_access(1'b1, 3'b010, 32'h500, 32'hAAAA_0000, 32'h0, 0, 0, 1'b0);
    run_access(1'b0, 3'b010, 32'h604, 32'h0, rd, 0, 0, 1'b0);
    lsu_valid = 1'b0;
    checks++; if (ob_addr !== 32'h604 || ob_we !== 1'b0) begin errors++; $display("FAIL b2b_second_addr got=%h/%b exp=00000604/0", ob_addr, ob_we); end
    checks++; if (ob_done_cyc !== 3 || ob_ld !== rd) begin errors++; $display("FAIL b2b_second_done got=%0d/%h exp=3/%h", ob_done_cyc, ob_ld, rd); end
  endtask

  task automatic test_random();
    logic        we, e, noise;
    logic [2:0]  f3;
    logic [31:0] a, d, rd, wd, ld;
    logic [3:0]  bm;
    int          gd, rv, exp_done;
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom_range(0, 1)); f3 = 3'($urandom_range(0, 7));
      a = $urandom; d = $urandom; rd = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = (f3[1:0] == 2'd0) ? a[1:0] : (f3[1:0] == 2'd1) ? {a[1], 1'b0} : 2'b00;
      gd = $urandom_range(0, 5); rv = $urandom_range(0, 5); noise = 1'($urandom_range(0, 1));
      ref_model(we, f3, a, d, rd, e, bm, wd, ld);
      exp_done = e ? 1 : we ? gd + 2 : gd + rv + 3;
      run_access(we, f3, a, d, rd, gd, rv, noise);
      lsu_valid = 1'b0;
      checks++; if (ob_done_cyc !== exp_done || ob_err !== e || ob_stall_ok !== 1'b1) begin errors++; $display("FAIL rnd_done[%0d] got=%0d/%b/%b exp=%0d/%b/1", n, ob_done_cyc, ob_err, ob_stall_ok, exp_done, e); end
      if (!e) begin
        checks++; if ({ob_addr, ob_we, ob_bmask} !== {a[31:2], 2'b00, we, bm} || ob_stable !== 1'b1) begin errors++; $display("FAIL rnd_bus[%0d] got=%h/%b/%b exp=%h/%b/%b", n, ob_addr, ob_we, ob_bmask, {a[31:2], 2'b00}, we, bm); end
      end
      if (!e && we) begin
        checks++; if (ob_wdata !== wd) begin errors++; $display("FAIL rnd_wdata[%0d] got=%h exp=%h", n, ob_wdata, wd); end
      end
      if (!we || e) begin
        checks++; if (ob_ld !== ld) begin errors++; $display("FAIL rnd_ld[%0d] f3=%b got=%h exp=%h", n, f3, ob_ld, ld); end
      end
      if ($urandom_range(0, 1) != 0) @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; lsu_valid = 1'b0; lsu_we = 1'b0; funct3 = 3'b000; addr = 32'h0; st_data = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    test_reset();
    test_store();
    test_load_ext();
    test_errors();
    test_timeout();
    test_reset_midflight();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsu_unit.md
Name: lsu_unit

Overview:
- Load/store unit directly downstream of the ALU.
- Takes the ALU result as the effective address and performs RV32I byte/half/word loads and stores on a data-memory bus with a req/gnt/rvalid handshake.
- Stalls the core (freezes PC and writeback) until the access completes, then returns sign- or zero-extended load data to writeback.
- Reports misaligned, illegal-size and timeout errors.

Parameters:
TIMEOUT_CYCLES, 16, cycles spent in REQ or WAIT (combined) before the access is abandoned with an error; range 2..255.

Ports:
i_clk  input  1  clock, all state on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_lsu_valid  input  1  current instruction is a load/store; held by core while o_stall=1
i_lsu_we  input  1  1=store, 0=load
i_funct3  input  3  RV32I size/sign field
i_addr  input  32  effective address (ALU o_alu_data)
i_st_data  input  32  rs2 value for stores
o_stall  output  1  core must hold PC/instruction
o_done  output  1  one-cycle pulse: access finished (ok or error)
o_ld_data  output  32  extended load result, valid while o_done=1
o_err  output  1  with o_done: misaligned, illegal funct3 or timeout
o_mem_req  output  1  bus request
o_mem_we  output  1  bus write enable
o_mem_addr  output  32  word-aligned address {addr[31:2],2'b00}
o_mem_wdata  output  32  lane-replicated store data
o_mem_bmask  output  4  byte enables
i_mem_gnt  input  1  request accepted this cycle
i_mem_rvalid  input  1  read data valid
i_mem_rdata  input  32  read data word

Behaviour:
- Reset (asynchronous, i_rst_n=0):
  - State=IDLE, timeout counter=0.
  - All outputs 0, o_ld_data=0.
  - o_mem_req drops immediately, even mid-transaction; any later rvalid/gnt is ignored.
- States: IDLE, REQ, WAIT, DONE.
- o_stall = i_lsu_valid & (state != DONE).
- IDLE with i_lsu_valid=1:
  - Capture i_lsu_we, i_funct3, i_addr, i_st_data into registers; all bus outputs come from the registers.
  - Legal: loads 000/001/010/100/101; stores 000/001/010.
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal or misaligned -> DONE with o_err=1 and no bus activity; otherwise -> REQ.
- REQ:
  - o_mem_req=1; addr/we/wdata/bmask stay stable until gnt.
  - On i_mem_gnt: store -> DONE; load -> WAIT.
  - i_mem_rvalid in REQ is ignored.
- WAIT:
  - o_mem_req=0.
  - On i_mem_rvalid: register the extended data -> DONE.
- DONE:
  - o_done=1 for exactly one cycle, o_stall=0 -> IDLE.
  - i_lsu_valid in the DONE cycle is not accepted; the next access starts the following cycle in IDLE.
- Timeout: counter clears on leaving IDLE and increments each cycle in REQ/WAIT. Reaching TIMEOUT_CYCLES -> DONE with o_err=1 and o_mem_req deasserted. gnt/rvalid in the same cycle as expiry wins over the timeout.
- Store lanes, with off=addr[1:0]:
  - SB: wdata={4{d[7:0]}}, bmask=4'b0001<<off.
  - SH: wdata={2{d[15:0]}}, bmask=4'b0011<<off.
  - SW: wdata=d, bmask=4'b1111.
- Load extraction: the byte/half is selected from rdata by off. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- Loads: o_mem_bmask=4'b0000, o_mem_we=0.
- o_ld_data holds its last value outside DONE. It is 0 after error completions.
- Latency:
  - Store with gnt on the first REQ cycle: o_done 2 cycles after acceptance.
  - Load with gnt on the first REQ cycle and rvalid one cycle later: o_done 3 cycles after acceptance.
  - Error at acceptance: o_done the cycle after.

Test Plan:
- SW addr=0x100, data=0xDEADBEEF, gnt immediate -> req with addr 0x100, bmask 1111, wdata 0xDEADBEEF; o_done 2 cycles after acceptance; o_err=0.
- SB addr=0x103, data=0x000000A5 -> addr 0x100, bmask 1000, wdata 0xA5A5A5A5.
- Load addr=0x202, rdata=0x80FF1234:
  - LH -> 0xFFFF80FF; LHU -> 0x000080FF.
  - LB at 0x203 -> 0xFFFFFF80; LBU -> 0x00000080.
- LW at 0x201 and funct3=011 load -> no o_mem_req; o_done next cycle with o_err=1. SH at 0x1 -> same.
- gnt withheld: req stays high with stable addr for 15 cycles; at cycle 16 (TIMEOUT_CYCLES) -> o_done + o_err, req low. Repeat with gnt delayed 5 cycles -> normal completion.
- Assert i_rst_n=0 during WAIT -> req/stall/done=0 immediately. Late rvalid after reset release -> ignored. Next LW completes normally.
